// File: rtl/bp_pkg.sv
// Shared types for the gshare predictor: counter encodings, FSM states, in-flight entry.
// No logic of its own; entry fields are sized for the largest legal table/history.
package bp_pkg;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned BP_IDX_MAX = 12;
  localparam int unsigned BP_GHR_MAX = 12;

  // Fields are zero-extended from INDEX_BITS/GHR_BITS of the instantiating design.
  typedef struct packed {
    logic [BP_IDX_MAX-1:0] idx;
    logic [BP_GHR_MAX-1:0] ghr;
    logic                  pred;
  } entry_t;

  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == CNT_ST) ? c : c + 2'd1;
    return (c == CNT_SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Decode/resolve bundle between the core (master) and the predictor (slave).
// Pure wiring; the core owns issue throttling via full/busy.
interface gshare_branch_predictor_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  decode_valid;
  logic [ADDR_WIDTH-1:0] decode_pc;
  logic [ADDR_WIDTH-1:0] decode_offset;
  logic [ADDR_WIDTH-1:0] branch_addr;
  logic                  prediction;
  logic                  resolve_valid;
  logic                  resolve_taken;
  logic                  mispredict;
  logic                  full;
  logic                  busy;
  logic                  protocol_err;
  logic [31:0]           stat_branches;
  logic [31:0]           stat_mispredicts;

  modport master (
    output decode_valid, decode_pc, decode_offset, resolve_valid, resolve_taken,
    input  branch_addr, prediction, mispredict, full, busy, protocol_err,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  decode_valid, decode_pc, decode_offset, resolve_valid, resolve_taken,
    output branch_addr, prediction, mispredict, full, busy, protocol_err,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/bp_inflight_fifo.sv
// Sync FIFO with flush; head is visible combinationally, push/pop take effect on posedge.
// Push is refused when full unless a pop happens the same cycle; pop on empty is ignored.
module bp_inflight_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare predictor: PC^GHR-indexed 2-bit counters, in-order resolve, GHR repair on mispredict; BP_STATS_EN adds stat counters.
// Prediction/mispredict are same-cycle combinational; no backpressure beyond full/busy, which decode must honour.
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned INDEX_BITS     = 8,
  parameter int unsigned GHR_BITS       = 6,
  parameter int unsigned INFLIGHT_DEPTH = 4,
  parameter logic [1:0]  COUNTER_INIT   = CNT_WNT
) (
  input logic                     clk,
  input logic                     rst,
  gshare_branch_predictor_if.slave bp
);
  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned CW      = $clog2(INFLIGHT_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic [GHR_BITS-1:0]   ghr_q;
  logic [1:0]            table_q [ENTRIES];

  logic                  run;
  logic [INDEX_BITS-1:0] dec_idx, upd_idx;
  logic                  push_req, pop_req, res_ok, push_ok;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         unused_fifo_count;
  entry_t                push_ent, head;
  logic                  unused_head;

  function automatic logic [GHR_BITS-1:0] ghr_shift(input logic [GHR_BITS-1:0] h, input logic b);
    return GHR_BITS'({h, b});
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep one entry per cycle; the pointer wrapping back to 0 ends INIT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + INDEX_BITS'(1);
      if (ptr_q == '1) state_d = ST_RUN;
    end
  end

  assign run      = (state_q == ST_RUN);
  assign bp.busy  = ~run;
  assign dec_idx  = bp.decode_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
  assign upd_idx  = head.idx[INDEX_BITS-1:0];

  assign bp.branch_addr = bp.decode_pc + bp.decode_offset;
  assign bp.prediction  = run & bp.decode_valid & table_q[dec_idx][1];

  assign push_req      = run & bp.decode_valid;
  assign pop_req       = run & bp.resolve_valid;
  assign res_ok        = pop_req & ~fifo_empty;
  assign bp.mispredict = res_ok & (bp.resolve_taken != head.pred);
  // A mispredict flushes the wrong path, including this cycle's decode.
  assign push_ok       = push_req & ~bp.mispredict & (~fifo_full | res_ok);
  assign bp.full       = fifo_full;
  assign unused_head   = ^head;

  always_comb begin
    push_ent                      = '0;
    push_ent.idx[INDEX_BITS-1:0]  = dec_idx;
    push_ent.ghr[GHR_BITS-1:0]    = ghr_q;
    push_ent.pred                 = bp.prediction;
  end

  bp_inflight_fifo #(
    .DEPTH (INFLIGHT_DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_ok),
    .push_dat (push_ent),
    .pop      (res_ok & ~bp.mispredict),
    .flush    (bp.mispredict),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (unused_fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q           <= '0;
      bp.protocol_err <= 1'b0;
    end else begin
      if (bp.mispredict)  ghr_q <= ghr_shift(head.ghr[GHR_BITS-1:0], bp.resolve_taken);
      else if (push_ok)   ghr_q <= ghr_shift(ghr_q, bp.prediction);
      if ((push_req && fifo_full && !res_ok) || (pop_req && fifo_empty))
        bp.protocol_err <= 1'b1;
    end
  end

  // Table has no reset: the INIT sweep rewrites every entry after each rst.
  always_ff @(posedge clk) begin
    if (!run)        table_q[ptr_q]   <= COUNTER_INIT;
    else if (res_ok) table_q[upd_idx] <= cnt_next(table_q[upd_idx], bp.resolve_taken);
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (res_ok && stat_br_q != 32'hFFFF_FFFF)        stat_br_q <= stat_br_q + 32'd1;
      if (bp.mispredict && stat_mp_q != 32'hFFFF_FFFF) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mp_q;
`else
  assign bp.stat_branches    = '0;
  assign bp.stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor (defaults: INDEX_BITS=8, GHR_BITS=6, depth 4).
// Driver queues hand-computed expectations per cycle; a negedge monitor pops and compares.
module tb_gshare_branch_predictor;

  typedef struct {
    string       name;
    logic        pred;
    logic        misp;
    logic        full;
    logic        busy;
    logic        perr;
    logic [31:0] addr;
  } exp_t;

`ifdef BP_STATS_EN
  localparam logic [31:0] EXP_BR = 32'd11;
  localparam logic [31:0] EXP_MP = 32'd4;
`else
  localparam logic [31:0] EXP_BR = 32'd0;
  localparam logic [31:0] EXP_MP = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  gshare_branch_predictor_if #(.ADDR_WIDTH(32)) bp ();

  gshare_branch_predictor dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.name, ".prediction"},   32'(bp.prediction),   32'(e.pred));
      check({e.name, ".mispredict"},   32'(bp.mispredict),   32'(e.misp));
      check({e.name, ".full"},         32'(bp.full),         32'(e.full));
      check({e.name, ".busy"},         32'(bp.busy),         32'(e.busy));
      check({e.name, ".protocol_err"}, 32'(bp.protocol_err), 32'(e.perr));
      check({e.name, ".branch_addr"},  bp.branch_addr,       e.addr);
    end
  end

  // Drives one cycle of inputs and queues that cycle's expected outputs.
  task automatic step(input string name, input logic dv, input logic [31:0] pc, input logic [31:0] off,
                      input logic rv, input logic rt,
                      input logic e_pred, input logic e_misp, input logic e_full,
                      input logic e_busy, input logic e_perr);
    exp_t e;
    bp.decode_valid  = dv;
    bp.decode_pc     = pc;
    bp.decode_offset = off;
    bp.resolve_valid = rv;
    bp.resolve_taken = rt;
    e.name = name; e.pred = e_pred; e.misp = e_misp; e.full = e_full;
    e.busy = e_busy; e.perr = e_perr; e.addr = pc + off;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bp.decode_valid  = 1'b0;
    bp.resolve_valid = 1'b0;
  endtask

  // Releases reset, pokes the design while busy, and measures the sweep length.
  task automatic run_init(input string tag);
    int  n;
    bit  done;
    rst = 1'b0;
    n   = 0;
    for (int i = 0; i < 4; i++) begin
      step({tag, ".init_ignore"}, 1'b1, 32'h100, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (bp.busy) n++;
      else done = 1'b1;
    end
    check({tag, ".busy_cycles"}, 32'(n), 32'd256);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bp.decode_valid  = 1'b0;
    bp.decode_pc     = '0;
    bp.decode_offset = '0;
    bp.resolve_valid = 1'b0;
    bp.resolve_taken = 1'b0;
    @(posedge clk);
    #1;
    // Held in reset: only busy is high even with both valids asserted.
    step("rst_state", 1'b1, 32'h100, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_init("init1");

    // Train idx 0x40, choosing PCs so PC[9:2]^GHR stays 0x40 as the GHR moves.
    //                                 dv    pc            off           rv    rt    pred  misp  full  busy  perr
    step("A1_dec_wnt",   1'b1, 32'h100, 32'h20,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("A2_res_t",     1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("A3_dec_wt",    1'b1, 32'h104, 32'h8,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("A4_res_t",     1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("A5_dec_st",    1'b1, 32'h10C, 32'h40,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("A6_res_t_sat", 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("A7_dec_st",    1'b1, 32'h11C, 32'h4,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("A8_res_nt",    1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("A9_dec_wt",    1'b1, 32'h138, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("A10_res_nt",   1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("A11_dec_wnt",  1'b1, 32'h170, 32'h10,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("A12_res_nt",   1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("A13_dec_snt",  1'b1, 32'h1E0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("A14_res_nt",   1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("A15_dec_sat0", 1'b1, 32'h1C0, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("A16_res_nt",   1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill the in-flight FIFO, overflow it, then push+pop while full.
    step("B1_push",      1'b1, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("B2_push",      1'b1, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("B3_push",      1'b1, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("B4_push",      1'b1, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("B5_push_full", 1'b1, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("B6_push_pop",  1'b1, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("B7_pop",       1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("B8_misp",      1'b1, 32'h4,   32'h10,       1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("B9_res_empty", 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("stat_branches",    bp.stat_branches,    EXP_BR);
    check("stat_mispredicts", bp.stat_mispredicts, EXP_MP);

    // Reset mid-RUN with two branches in flight.
    step("C1_push",      1'b1, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("C2_push",      1'b1, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("stat_branches_rst",    bp.stat_branches,    32'd0);
    check("stat_mispredicts_rst", bp.stat_mispredicts, 32'd0);
    step("C3_rst_mid",   1'b1, 32'hFFFF_FFFC, 32'h8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_init("init2");
    step("D1_res_empty", 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("D2_err_stick", 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
